// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the sequenced ALU arbiter.
//   DW          : ALU datapath width (wide operands are 2*DW)
//   NREQ        : number of requesters (fixed at 2)
//   alu_op_t    : ALU opcode encoding as understood by the external ALU
//   seq_state_t : sequencing FSM states
//   carry_out   : carry/borrow out of the low-byte pass
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DW   = 8;
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        AND = 2'd0,
        ADD = 2'd1,
        XOR = 2'd2,
        SUB = 2'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Carry out of an unsigned ADD shows up as a wrapped sum smaller than an
    // addend; a borrow out of SUB happens exactly when the minuend is smaller.
    function automatic logic carry_out(input alu_op_t        op,
                                       input logic [DW-1:0] a,
                                       input logic [DW-1:0] b,
                                       input logic [DW-1:0] r);
        case (op)
            ADD:     return (r < a);
            SUB:     return (a < b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant. Holds only the "last granted" pointer.
//   clk, reset : clock, synchronous active-high reset
//   req [1:0]  : candidate requests (already qualified by the caller)
//   gnt [1:0]  : combinational one-hot grant; a nonzero grant is taken as
//                accepted on the next clk edge and advances the pointer
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last = index of the requester granted most recently; resets to 1 so
    // requester 0 wins the first contested grant.
    logic last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_seq_arbiter.sv
// ---------------------------------------------------------------------------
// alu_seq_arbiter
// Shares one 8-bit ALU between two requesters. 16-bit operations run as a
// low-byte pass, a high-byte pass and, for ADD/SUB with carry/borrow out of
// the low byte, a FIX pass that applies +1/-1 to the high byte.
//   CLK, Reset        : clock, synchronous active-high reset
//   ReqValid/ReqReady : per-requester request handshake (see below)
//   ReqOp/ReqWide     : opcode and width per requester
//   ReqA/ReqB         : 16-bit operands per requester
//   RspValid/RspData  : one-cycle one-hot response pulse and its 16-bit data
//   Busy              : high whenever the sequencer is not IDLE
//   ALUOp/ALUSrcA/ALUSrcB/Result : port to the external combinational ALU
//   dbg_state         : current sequencer state
//
// Handshake: a requester raises ReqValid and holds it with stable payload
// until it sees its ReqReady bit high; the request is accepted on that CLK
// edge. ReqReady is only ever high in IDLE. There is no response
// backpressure: RspValid is a single-cycle pulse that must be taken.
// ---------------------------------------------------------------------------
module alu_seq_arbiter
    import alu_pkg::*;
(
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [1:0]           ReqValid,
    input  logic [1:0][1:0]      ReqOp,
    input  logic [1:0]           ReqWide,
    input  logic [1:0][2*DW-1:0] ReqA,
    input  logic [1:0][2*DW-1:0] ReqB,
    output logic [1:0]           ReqReady,
    output logic [1:0]           RspValid,
    output logic [2*DW-1:0]      RspData,
    output logic                 Busy,
    output logic [1:0]           ALUOp,
    output logic [DW-1:0]        ALUSrcA,
    output logic [DW-1:0]        ALUSrcB,
    input  logic [DW-1:0]        Result,
    output seq_state_t           dbg_state
);

    seq_state_t      state;
    logic            owner;
    alu_op_t         op;
    logic            wide;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
    logic [DW-1:0]   lo;
    logic [DW-1:0]   hi;
    logic            carry;

    logic [1:0]      arb_req;
    logic            gidx;

    assign dbg_state = state;

    // Requests are only offered to the arbiter in IDLE, so the pointer moves
    // exactly on accept edges.
    assign arb_req = (state == IDLE) ? ReqValid : 2'b00;
    assign gidx    = ReqReady[1];

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .reset (Reset),
        .req   (arb_req),
        .gnt   (ReqReady)
    );

    // All outputs except ReqReady are registered: each transition loads the
    // ALU operands for the state being entered, so the ALU sees them for the
    // whole of that state and Result is captured at its end.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            op       <= AND;
            wide     <= 1'b0;
            a        <= '0;
            b        <= '0;
            lo       <= '0;
            hi       <= '0;
            carry    <= 1'b0;
            RspValid <= 2'b00;
            RspData  <= '0;
            Busy     <= 1'b0;
            ALUOp    <= 2'b00;
            ALUSrcA  <= '0;
            ALUSrcB  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    RspValid <= 2'b00;
                    RspData  <= '0;
                    if (|ReqReady) begin
                        owner   <= gidx;
                        op      <= alu_op_t'(ReqOp[gidx]);
                        wide    <= ReqWide[gidx];
                        a       <= ReqA[gidx];
                        b       <= ReqB[gidx];
                        lo      <= '0;
                        hi      <= '0;
                        carry   <= 1'b0;
                        ALUOp   <= ReqOp[gidx];
                        ALUSrcA <= ReqA[gidx][DW-1:0];
                        ALUSrcB <= ReqB[gidx][DW-1:0];
                        Busy    <= 1'b1;
                        state   <= LO;
                    end
                end

                LO: begin
                    lo    <= Result;
                    carry <= carry_out(op, a[DW-1:0], b[DW-1:0], Result);
                    if (wide) begin
                        ALUSrcA <= a[2*DW-1:DW];
                        ALUSrcB <= b[2*DW-1:DW];
                        state   <= HI;
                    end else begin
                        ALUOp    <= 2'b00;
                        ALUSrcA  <= '0;
                        ALUSrcB  <= '0;
                        RspValid <= owner ? 2'b10 : 2'b01;
                        RspData  <= {{DW{1'b0}}, Result};
                        state    <= DONE;
                    end
                end

                HI: begin
                    hi <= Result;
                    if (((op == ADD) || (op == SUB)) && carry) begin
                        // Same opcode with SrcB=1 turns ADD into +carry and
                        // SUB into -borrow on the high byte.
                        ALUSrcA <= Result;
                        ALUSrcB <= {{(DW-1){1'b0}}, 1'b1};
                        state   <= FIX;
                    end else begin
                        ALUOp    <= 2'b00;
                        ALUSrcA  <= '0;
                        ALUSrcB  <= '0;
                        RspValid <= owner ? 2'b10 : 2'b01;
                        RspData  <= {Result, lo};
                        state    <= DONE;
                    end
                end

                FIX: begin
                    hi       <= Result;
                    ALUOp    <= 2'b00;
                    ALUSrcA  <= '0;
                    ALUSrcB  <= '0;
                    RspValid <= owner ? 2'b10 : 2'b01;
                    RspData  <= {Result, lo};
                    state    <= DONE;
                end

                DONE: begin
                    RspValid <= 2'b00;
                    RspData  <= '0;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    RspValid <= 2'b00;
                    RspData  <= '0;
                    Busy     <= 1'b0;
                    ALUOp    <= 2'b00;
                    ALUSrcA  <= '0;
                    ALUSrcB  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_arbiter
// Self-checking bench for alu_seq_arbiter with a behavioural ALU attached.
// ---------------------------------------------------------------------------
module tb_alu_seq_arbiter;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic                 CLK = 1'b0;
    logic                 Reset = 1'b1;
    logic [1:0]           ReqValid = '0;
    logic [1:0][1:0]      ReqOp = '0;
    logic [1:0]           ReqWide = '0;
    logic [1:0][15:0]     ReqA = '0;
    logic [1:0][15:0]     ReqB = '0;
    logic [1:0]           ReqReady;
    logic [1:0]           RspValid;
    logic [15:0]          RspData;
    logic                 Busy;
    logic [1:0]           ALUOp;
    logic [7:0]           ALUSrcA;
    logic [7:0]           ALUSrcB;
    logic [7:0]           Result;
    seq_state_t           dbg_state;

    always #5 CLK = ~CLK;

    alu_seq_arbiter dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqOp     (ReqOp),
        .ReqWide   (ReqWide),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .ReqReady  (ReqReady),
        .RspValid  (RspValid),
        .RspData   (RspData),
        .Busy      (Busy),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .Result    (Result),
        .dbg_state (dbg_state)
    );

    // External ALU: AND=0, ADD=1, XOR=2, SUB=3, 8-bit wrap.
    always_comb begin
        case (ALUOp)
            2'd0:    Result = ALUSrcA & ALUSrcB;
            2'd1:    Result = 8'(ALUSrcA + ALUSrcB);
            2'd2:    Result = ALUSrcA ^ ALUSrcB;
            default: Result = 8'(ALUSrcA - ALUSrcB);
        endcase
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [17:0] pass_log [1:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: whole-word unsigned arithmetic modulo 2^16; narrow
    // ops use only the low bytes and return a zero high byte.
    function automatic logic [15:0] model_res(input logic [1:0] op, input logic w,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, r;
        x = w ? a : {8'h00, a[7:0]};
        y = w ? b : {8'h00, b[7:0]};
        case (op)
            2'd0:    r = x & y;
            2'd1:    r = x + y;
            2'd2:    r = x ^ y;
            default: r = x - y;
        endcase
        return w ? r : {8'h00, r[7:0]};
    endfunction

    // Latency from accept edge to response: one ALU pass per byte, plus one
    // when the low-byte ADD/SUB spills into the high byte.
    function automatic int model_lat(input logic [1:0] op, input logic w,
                                     input logic [15:0] a, input logic [15:0] b);
        int sum_lo;
        if (!w) return 2;
        sum_lo = int'(a[7:0]) + int'(b[7:0]);
        if (op == 2'd1 && sum_lo > 255) return 4;
        if (op == 2'd3 && a[7:0] < b[7:0]) return 4;
        return 3;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        Reset    = 1'b1;
        ReqValid = '0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    // Issue one request from requester r, wait for accept and response, and
    // compare response, latency and the first ALU pass.
    task automatic run_req(input int r, input logic [1:0] op, input logic w,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_d, input int exp_lat, input string name);
        bit got;
        int lat;
        @(posedge CLK); #1;
        ReqOp[r]    = op;
        ReqWide[r]  = w;
        ReqA[r]     = a;
        ReqB[r]     = b;
        ReqValid[r] = 1'b1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (ReqReady[r]) begin
                got = 1;
                break;
            end
            @(posedge CLK); #1;
        end
        check({name, "_accept"}, 32'(got), 32'd1);
        @(posedge CLK); #1;
        ReqValid[r] = 1'b0;
        if (!got) return;
        for (int k = 1; k <= 4; k++) pass_log[k] = '0;
        got = 0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k <= 4) pass_log[k] = {ALUOp, ALUSrcA, ALUSrcB};
            if (k == 1) check({name, "_pass1"}, 32'({ALUOp, ALUSrcA, ALUSrcB}),
                              32'({op, a[7:0], b[7:0]}));
            if (RspValid != 2'b00) begin
                got = 1;
                lat = k;
                break;
            end
            @(posedge CLK); #1;
        end
        check({name, "_rsp_seen"}, 32'(got), 32'd1);
        if (!got) return;
        check({name, "_rspvalid"}, 32'(RspValid), (r == 1) ? 32'd2 : 32'd1);
        check({name, "_data"}, 32'(RspData), 32'(exp_d));
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy"}, 32'(Busy), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    initial begin : main
        int          arb_cyc[$];
        int          arb_idx[$];
        logic [15:0] rsp_exp;
        bit          seen_rsp;

        tbl[0] = '{2'd1, 1'b0, 16'h0005, 16'h0003, 16'h0008, 2};
        tbl[1] = '{2'd1, 1'b1, 16'h01FF, 16'h0001, 16'h0200, 4};
        tbl[2] = '{2'd3, 1'b1, 16'h0100, 16'h0001, 16'h00FF, 4};
        tbl[3] = '{2'd2, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 3};
        tbl[4] = '{2'd1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 4};
        tbl[5] = '{2'd3, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4};
        tbl[6] = '{2'd0, 1'b0, 16'hAB3C, 16'hCD0F, 16'h000C, 2};
        tbl[7] = '{2'd3, 1'b0, 16'h0003, 16'h0005, 16'h00FE, 2};
        tbl[8] = '{2'd1, 1'b1, 16'h1234, 16'h0101, 16'h1335, 3};
        tbl[9] = '{2'd0, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 3};

        // ---- reset state ----
        do_reset();
        @(negedge CLK);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_outputs", 32'({ReqReady, RspValid, Busy, ALUOp}), 32'd0);
        check("rst_rspdata", 32'(RspData), 32'd0);
        check("rst_srcs", 32'({ALUSrcA, ALUSrcB}), 32'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            run_req(i % 2, tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b,
                    tbl[i].exp_d, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // ---- wide ADD with carry: all three ALU passes ----
        run_req(0, 2'd1, 1'b1, 16'h01FF, 16'h0001, 16'h0200, 4, "addc");
        check("addc_pass2", 32'(pass_log[2]), 32'({2'd1, 8'h01, 8'h00}));
        check("addc_pass3", 32'(pass_log[3]), 32'({2'd1, 8'h01, 8'h01}));

        // ---- wide SUB with borrow: FIX pass is SUB hi,1 ----
        run_req(1, 2'd3, 1'b1, 16'h0100, 16'h0001, 16'h00FF, 4, "subb");
        check("subb_pass3", 32'(pass_log[3]), 32'({2'd3, 8'h01, 8'h01}));

        // ---- wide XOR: no FIX pass, ALU idle in the DONE cycle ----
        run_req(0, 2'd2, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 3, "xorw");
        check("xorw_pass3_idle", 32'(pass_log[3]), 32'd0);

        // ---- arbitration: both held from the first cycle after reset ----
        do_reset();
        ReqOp[0] = 2'd1; ReqWide[0] = 1'b0; ReqA[0] = 16'h0010; ReqB[0] = 16'h0001;
        ReqOp[1] = 2'd2; ReqWide[1] = 1'b0; ReqA[1] = 16'h00FF; ReqB[1] = 16'h000F;
        ReqValid = 2'b11;
        exp_q.delete();
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (ReqReady != 2'b00) begin
                arb_cyc.push_back(c);
                arb_idx.push_back(ReqReady[1] ? 1 : 0);
                exp_q.push_back(ReqReady[1] ? model_res(2'd2, 1'b0, 16'h00FF, 16'h000F)
                                            : model_res(2'd1, 1'b0, 16'h0010, 16'h0001));
            end
            if (RspValid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("arb_unexpected_rsp", 32'(RspValid), 32'd0);
                end else begin
                    rsp_exp = exp_q.pop_front();
                    check("arb_rsp_data", 32'(RspData), 32'(rsp_exp));
                end
            end
            @(posedge CLK); #1;
        end
        ReqValid = 2'b00;
        check("arb_grant_count", 32'(arb_cyc.size()), 32'd5);
        for (int g = 0; g < 4 && g < arb_cyc.size(); g++) begin
            check($sformatf("arb_grant%0d_idx", g), 32'(arb_idx[g]), 32'(g % 2));
            check($sformatf("arb_grant%0d_cyc", g), 32'(arb_cyc[g]), 32'(3 * g));
        end

        // ---- reset in the HI state of a wide ADD ----
        @(posedge CLK); #1;
        ReqOp[0] = 2'd1; ReqWide[0] = 1'b1; ReqA[0] = 16'h01FF; ReqB[0] = 16'h0001;
        ReqValid[0] = 1'b1;
        @(negedge CLK);
        check("rmid_accept", 32'(ReqReady), 32'd1);
        @(posedge CLK); #1;
        ReqValid[0] = 1'b0;
        @(posedge CLK); #1;
        check("rmid_in_hi", 32'(dbg_state), 32'(HI));
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(negedge CLK);
        check("rmid_state", 32'(dbg_state), 32'(IDLE));
        check("rmid_outputs", 32'({RspValid, Busy, ALUOp, ALUSrcA, ALUSrcB}), 32'd0);
        check("rmid_rspdata", 32'(RspData), 32'd0);
        seen_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (RspValid != 2'b00) seen_rsp = 1;
        end
        check("rmid_no_rsp", 32'(seen_rsp), 32'd0);
        run_req(0, 2'd0, 1'b0, 16'h003C, 16'h000F, 16'h000C, 2, "rmid_and");

        // ---- randomized requests against the reference model ----
        for (int i = 0; i < 150; i++) begin
            int          r;
            logic [1:0]  op;
            logic        w;
            logic [15:0] a, b;
            r  = $urandom_range(0, 1);
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFF;
            if ($urandom_range(0, 5) == 0) b = 16'h0001;
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            run_req(r, op, w, a, b, model_res(op, w, a, b), model_lat(op, w, a, b),
                    $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
Shares the single 8-bit, 2-bit-opcode ALU (AND=0, ADD=1, XOR=2, SUB=3) between two requesters, for example the execute stage and the address/branch unit. Each request carries a 16-bit operation or an 8-bit (narrow) operation. Wide operations are sequenced as multiple 8-bit ALU passes, with carry/borrow chaining done by the controller. The block sits between the requesters and the ALU's ALUOp/ALUSrcA/ALUSrcB/Result ports.

Parameters:
DW, 8, ALU datapath width; wide operands are 2*DW.
NREQ, 2, number of requesters; only 2 is supported.

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high reset
ReqValid  in  2  per-requester request valid; held until that requester's ReqReady
ReqOp  in  2x2  per-requester ALU opcode
ReqWide  in  2  1 = 16-bit operation; 0 = 8-bit operation using the low bytes
ReqA  in  2x16  per-requester operand A
ReqB  in  2x16  per-requester operand B
ReqReady  out  2  one-hot grant; the request is accepted on the CLK edge where it is high
RspValid  out  2  one-hot, one-cycle pulse to the owning requester
RspData  out  16  result; valid only while RspValid is nonzero
Busy  out  1  high in every state except IDLE
ALUOp  out  2  to ALU
ALUSrcA  out  8  to ALU
ALUSrcB  out  8  to ALU
Result  in  8  from ALU (combinational)

Behaviour:
- One clock (CLK); reset is synchronous and active-high (Reset).
- States: IDLE, LO, HI, FIX, DONE.
- Registered state: state, owner, op, wide, A, B, lo byte, hi byte, carry flag, round-robin pointer.

Grant (IDLE only):
- ReqReady is combinational from ReqValid and the pointer.
- One requester valid: grant it.
- Both valid: grant the requester other than the last one granted.
- The pointer resets to "last = 1", so requester 0 wins first.
- On grant: latch the request, record owner, update the pointer, go to LO.
- Outside IDLE, ReqReady = 0.

LO state:
- ALUOp = op, ALUSrcA = A[7:0], ALUSrcB = B[7:0].
- Capture Result into the lo register.
- Compute carry:
  - ADD: carry = (Result < A[7:0]).
  - SUB: carry = (A[7:0] < B[7:0]).
  - AND/XOR: carry = 0.
- Next state: HI if wide, else DONE.

HI state:
- ALUOp = op, ALUSrcA = A[15:8], ALUSrcB = B[15:8].
- Capture Result into the hi register.
- Next state: FIX if (op is ADD or SUB) and carry = 1, else DONE.

FIX state:
- ALUOp = op (ADD adds the carry, SUB subtracts the borrow), ALUSrcA = hi, ALUSrcB = 8'h01.
- Capture Result into the hi register; go to DONE.

DONE state:
- RspValid[owner] = 1.
- RspData = wide ? {hi, lo} : {8'h00, lo}.
- Next state: IDLE; no new grant in the same cycle.

Outputs and timing:
- In IDLE and DONE, ALUOp = 0, ALUSrcA = 0, ALUSrcB = 0.
- Latency, counted from the accept edge to the RspValid cycle:
  - narrow: 2 cycles
  - wide AND/XOR, or wide ADD/SUB without carry: 3 cycles
  - wide ADD/SUB with carry: 4 cycles
- Maximum throughput is one request per latency + 1 cycles.

Rules and boundaries:
- Arithmetic is unsigned and modulo 2^16; there is no overflow output.
  - 0xFFFF + 0x0001 = 0x0000.
  - 0x0000 - 0x0001 = 0xFFFF.
- Narrow operations ignore A[15:8] and B[15:8].
- There is no response backpressure: a requester must accept RspValid in the cycle it is asserted.
- A requester may raise ReqValid again in the cycle after its own RspValid.
- ReqValid dropping while ungranted is legal; no state changes.
- Reset at any state:
  - next state is IDLE, pointer is "last = 1";
  - all outputs are 0, carry/lo/hi are 0;
  - an in-flight operation is abandoned and never responds.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum: AND=2'd0, ADD=2'd1, XOR=2'd2, SUB=2'd3
  - seq_state_t enum: IDLE, LO, HI, FIX, DONE
  - constant DW = 8
- One sub-module, rr_arbiter2: 2-way round-robin grant with a pointer register; holds the pointer only.
- The top level holds the sequencing FSM and the operand/result registers.
- The ALU itself is instantiated outside this block.

Test Plan:
- Narrow ADD: req0 with ReqOp=1, A=0x0005, B=0x0003, Wide=0 -> ReqReady[0] at cycle 0, ALUOp=1 with SrcA=0x05/SrcB=0x03 at cycle 1, RspValid=2'b01 with RspData=0x0008 at cycle 2.
- Wide ADD with carry: 0x01FF + 0x0001 -> ALU passes (ADD 0xFF,0x01), (ADD 0x01,0x00), (ADD 0x01,0x01); RspData=0x0200 at cycle 4.
- Wide SUB with borrow: 0x0100 - 0x0001 -> FIX pass uses SUB with SrcB=0x01; RspData=0x00FF at cycle 4. Wide XOR: 0xF0F0 ^ 0xFF00 -> RspData=0x0FF0 at cycle 3, no FIX state.
- Arbitration: both ReqValid high from the first cycle after reset -> req0 granted first, req1 granted in the IDLE cycle after req0's DONE; requests held continuously alternate 0,1,0,1.
- Reset mid-op: assert Reset in HI of a wide ADD -> next cycle IDLE, all outputs 0, no RspValid; a following narrow AND 0x3C & 0x0F returns 0x000C normally.
- Wrap: wide ADD 0xFFFF + 0x0001 -> RspData=0x0000.
